// File: rtl/norm_shift_if.sv
// Valid/ready bundle between the clz output and the normaliser.
// The master drives inputs and out_ready; the slave is the normaliser.
interface norm_shift_if #(
  parameter int WIDTH = 16,
  parameter int EXP_W = 8,
  parameter int LZ_W  = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mant;
  logic [EXP_W-1:0] in_exp;
  logic [LZ_W-1:0]  in_lz;
  logic             in_lz_valid;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic             out_zero;
  logic             out_uflow;

  modport master (
    output in_valid,
    input  in_ready,
    output in_mant,
    output in_exp,
    output in_lz,
    output in_lz_valid,
    input  out_valid,
    output out_ready,
    input  out_mant,
    input  out_exp,
    input  out_zero,
    input  out_uflow
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_mant,
    input  in_exp,
    input  in_lz,
    input  in_lz_valid,
    output out_valid,
    input  out_ready,
    output out_mant,
    output out_exp,
    output out_zero,
    output out_uflow
  );
endinterface

// File: rtl/norm_shift.sv
// Mantissa normaliser: S1 clamps the shift against the exponent,
// S2 applies the left shift and drives the result registers.
module norm_shift #(
  parameter int WIDTH = 16,
  parameter int EXP_W = 8,
  parameter int LZ_W  = $clog2(WIDTH)
) (
  input logic          clk,
  input logic          rst,
  norm_shift_if.slave  bus
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] mant;
    logic [LZ_W-1:0]  shift;
    logic [EXP_W-1:0] exp;
    logic             zero;
    logic             uflow;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] mant;
    logic [EXP_W-1:0] exp;
    logic             zero;
    logic             uflow;
  } s2_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic             s2_load;
  logic             in_ready;
  logic             in_fire;
  logic             lz_nz;
  logic             lz_fits;
  logic [EXP_W-1:0] lz_ext;

  assign s2_load  = !s2_q.valid | bus.out_ready;
  assign in_ready = !s1_q.valid | s2_load;
  assign in_fire  = bus.in_valid & in_ready;

  assign lz_nz   = bus.in_lz_valid;
  assign lz_ext  = EXP_W'(bus.in_lz);
  assign lz_fits = lz_ext <= bus.in_exp;

  // Clamp the shift so the exponent bottoms out at zero
  always_comb begin
    s1_d = s1_q;
    if (in_fire) begin
      s1_d.valid = 1'b1;
      unique case (1'b1)
        !lz_nz: begin
          s1_d.mant  = '0;
          s1_d.shift = '0;
          s1_d.exp   = '0;
          s1_d.zero  = 1'b1;
          s1_d.uflow = 1'b0;
        end
        lz_nz & lz_fits: begin
          s1_d.mant  = bus.in_mant;
          s1_d.shift = bus.in_lz;
          s1_d.exp   = bus.in_exp - lz_ext;
          s1_d.zero  = 1'b0;
          s1_d.uflow = 1'b0;
        end
        lz_nz & !lz_fits: begin
          s1_d.mant  = bus.in_mant;
          s1_d.shift = bus.in_exp[LZ_W-1:0];
          s1_d.exp   = '0;
          s1_d.zero  = 1'b0;
          s1_d.uflow = 1'b1;
        end
        default: s1_d = s1_q;
      endcase
    end else if (s2_load) begin
      s1_d.valid = 1'b0;
    end
  end

  always_comb begin
    s2_d = s2_q;
    if (s2_load) begin
      s2_d.valid = s1_q.valid;
      if (s1_q.valid) begin
        s2_d.mant  = s1_q.mant << s1_q.shift;
        s2_d.exp   = s1_q.exp;
        s2_d.zero  = s1_q.zero;
        s2_d.uflow = s1_q.uflow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_q.valid;
  assign bus.out_mant  = s2_q.mant;
  assign bus.out_exp   = s2_q.exp;
  assign bus.out_zero  = s2_q.zero;
  assign bus.out_uflow = s2_q.uflow;

endmodule

// File: tb/tb_norm_shift.sv
// Directed bench for norm_shift: single transfers, boundaries,
// a stalled back-to-back burst and reset while full.
module tb_norm_shift;
  localparam int W = 16;
  localparam int E = 8;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  norm_shift_if #(.WIDTH(W), .EXP_W(E), .LZ_W(L)) bus ();

  norm_shift #(.WIDTH(W), .EXP_W(E), .LZ_W(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] req);
    total_cnt++;
    assert (obs === req) pass_cnt++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] m, input logic [7:0] e,
                       input logic [3:0] lz, input logic v);
    bus.in_valid    = 1'b1;
    bus.in_mant     = m;
    bus.in_exp      = e;
    bus.in_lz       = lz;
    bus.in_lz_valid = v;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic outs(input string tag, input logic [15:0] m,
                      input logic [7:0] e, input logic z, input logic u);
    check({tag, "_vld"}, 32'(bus.out_valid), 32'(1));
    check({tag, "_mant"}, 32'(bus.out_mant), 32'(m));
    check({tag, "_exp"}, 32'(bus.out_exp), 32'(e));
    check({tag, "_zero"}, 32'(bus.out_zero), 32'(z));
    check({tag, "_uflow"}, 32'(bus.out_uflow), 32'(u));
  endtask

  task automatic single(input string tag,
                        input logic [15:0] m, input logic [7:0] e,
                        input logic [3:0] lz, input logic v,
                        input logic [15:0] om, input logic [7:0] oe,
                        input logic oz, input logic ou);
    bus.out_ready = 1'b1;
    drive(m, e, lz, v);
    #1;
    check({tag, "_ird"}, 32'(bus.in_ready), 32'(1));
    step();
    idle();
    check({tag, "_lat1"}, 32'(bus.out_valid), 32'(0));
    step();
    outs(tag, om, oe, oz, ou);
    step();
    check({tag, "_drain"}, 32'(bus.out_valid), 32'(0));
  endtask

  logic [15:0] vm [8];
  logic [15:0] vo [8];
  int sent, rcv, occ;
  logic in_f, out_f, stall_prev;
  logic [15:0] held;

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_mant     = '0;
    bus.in_exp      = '0;
    bus.in_lz       = '0;
    bus.in_lz_valid = 1'b0;
    bus.out_ready   = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_vld", 32'(bus.out_valid), 32'(0));
    check("rst_ird", 32'(bus.in_ready), 32'(1));
    check("rst_mant", 32'(bus.out_mant), 32'(0));
    check("rst_exp", 32'(bus.out_exp), 32'(0));
    check("rst_zero", 32'(bus.out_zero), 32'(0));
    check("rst_uflow", 32'(bus.out_uflow), 32'(0));

    single("t1", 16'h0F00, 8'd20, 4'd4, 1'b1, 16'hF000, 8'd16, 1'b0, 1'b0);
    single("t2", 16'h0001, 8'd5, 4'd15, 1'b1, 16'h0020, 8'd0, 1'b0, 1'b1);
    single("t3", 16'h0000, 8'd37, 4'd0, 1'b0, 16'h0000, 8'd0, 1'b1, 1'b0);
    single("t4", 16'h8000, 8'd0, 4'd0, 1'b1, 16'h8000, 8'd0, 1'b0, 1'b0);
    single("lzeq", 16'h0010, 8'd11, 4'd11, 1'b1, 16'h8000, 8'd0, 1'b0, 1'b0);
    single("lz0", 16'hABCD, 8'd9, 4'd0, 1'b1, 16'hABCD, 8'd9, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      vo[i] = 16'h8000 | (16'(i) << 8);
      vm[i] = vo[i] >> i;
    end
    sent = 0;
    rcv = 0;
    occ = 0;
    stall_prev = 1'b0;
    held = '0;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      bus.out_ready = (c % 2 == 0);
      if (sent < 8) drive(vm[sent], 8'(50 + sent), 4'(sent), 1'b1);
      else idle();
      #1;
      check("t5_ird", 32'(bus.in_ready),
            32'(!(occ == 2 && !bus.out_ready)));
      if (stall_prev) begin
        check("t5_hold_v", 32'(bus.out_valid), 32'(1));
        check("t5_hold_m", 32'(bus.out_mant), 32'(held));
      end
      in_f  = bus.in_valid & bus.in_ready;
      out_f = bus.out_valid & bus.out_ready;
      if (out_f) begin
        if (rcv < 8) begin
          check("t5_mant", 32'(bus.out_mant), 32'(vo[rcv]));
          check("t5_exp", 32'(bus.out_exp), 32'(50));
        end
        rcv++;
      end
      stall_prev = bus.out_valid & !bus.out_ready;
      held = bus.out_mant;
      if (in_f) sent++;
      occ = occ + int'(in_f) - int'(out_f);
      step();
    end
    idle();
    check("t5_count", 32'(rcv), 32'(8));

    bus.out_ready = 1'b0;
    drive(16'h0F00, 8'd20, 4'd4, 1'b1);
    step();
    drive(16'h0001, 8'd5, 4'd15, 1'b1);
    #1;
    check("t6_ird_b", 32'(bus.in_ready), 32'(1));
    step();
    idle();
    check("t6_full_ird", 32'(bus.in_ready), 32'(0));
    check("t6_full_vld", 32'(bus.out_valid), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_vld", 32'(bus.out_valid), 32'(0));
    check("t6_rst_ird", 32'(bus.in_ready), 32'(1));
    check("t6_rst_mant", 32'(bus.out_mant), 32'(0));
    check("t6_rst_exp", 32'(bus.out_exp), 32'(0));
    check("t6_rst_zero", 32'(bus.out_zero), 32'(0));
    check("t6_rst_uflow", 32'(bus.out_uflow), 32'(0));
    bus.out_ready = 1'b1;
    drive(16'h0030, 8'd40, 4'd10, 1'b1);
    step();
    idle();
    check("t6_lat1", 32'(bus.out_valid), 32'(0));
    step();
    outs("t6_post", 16'hC000, 8'd30, 1'b0, 1'b0);
    step();
    check("t6_drain", 32'(bus.out_valid), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
